// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared constants and types for the multi-phase CPU sequencer.
// Optional feature macro: CPU_SEQ_ILLEGAL_TRAP_EN (adds the TRAP state).
package cpu_seq_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned INS_W     = 32;
  localparam int unsigned ALU_W     = 3;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_LW = 7'h03;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_S  = 7'h23;
  localparam logic [6:0] OP_B  = 7'h63;
  localparam logic [6:0] OP_J  = 7'h6F;

  // ALU operation codes consumed by the execute stage
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ENTRY,
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB,
    S_HALT
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  // Decoded view of the instruction register
  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             is_r;
    logic             is_lw;
    logic             is_s;
    logic             is_i;
    logic             is_j;
    logic             is_b;
    logic             illegal;
  } dec_t;

endpackage

// File: rtl/cpu_seq_ctrl_alu_dec.sv
// Combinational instruction classifier and ALU-op decoder.
module cpu_seq_ctrl_alu_dec
  import cpu_seq_ctrl_pkg::*;
(
  input  logic [INS_W-1:0] ir,
  output dec_t             dec_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign funct3         = ir[14:12];
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  // Classify the opcode and pick the ALU operation; unknown opcodes flag illegal
  always_comb begin
    dec_c        = '0;
    dec_c.alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        dec_c.is_r = 1'b1;
        case (funct3)
          3'b000:  dec_c.alu_op = ir[30] ? ALU_SUB : ALU_ADD;
          3'b111:  dec_c.alu_op = ALU_AND;
          3'b110:  dec_c.alu_op = ALU_OR;
          3'b010:  dec_c.alu_op = ALU_SLT;
          default: dec_c.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: dec_c.is_lw = 1'b1;
      OP_I:  dec_c.is_i  = 1'b1;
      OP_S:  dec_c.is_s  = 1'b1;
      OP_J:  dec_c.is_j  = 1'b1;
      OP_B: begin
        dec_c.is_b   = 1'b1;
        dec_c.alu_op = ALU_SUB;
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-phase sequencer stepping each instruction through IF/ID/EX/MEM/WB.
// Define CPU_SEQ_ILLEGAL_TRAP_EN to trap unknown opcodes (adds port illegal).
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] max_ins,
  input  logic [INS_W-1:0] ins,
  output logic [INS_W-1:0] ir,
  output logic             int_req,
  output logic             pc_en,
  output logic             if_en,
  output logic             ex_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             wb_en,
  output logic [ALU_W-1:0] alu_op,
  output logic             busy,
  output logic             halted,
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] ins_count
);

  state_e           state_q,   state_d;
  logic [INS_W-1:0] ir_q,      ir_d;
  logic [ALU_W-1:0] alu_op_q,  alu_op_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             int_req_q, int_req_d;
  logic             pc_en_q,   pc_en_d;
  logic             if_en_q,   if_en_d;
  logic             ex_en_q,   ex_en_d;
  logic             mem_rd_q,  mem_rd_d;
  logic             mem_wr_q,  mem_wr_d;
  logic             wb_en_q,   wb_en_d;
  logic             busy_q,    busy_d;
  logic             halted_q,  halted_d;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif
  dec_t             dec_c;
  logic             writes_rf_c;

  cpu_seq_ctrl_alu_dec u_dec (
    .ir    (ir_q),
    .dec_c (dec_c)
  );

  assign writes_rf_c = dec_c.is_r | dec_c.is_lw | dec_c.is_i | dec_c.is_j;

  // Next state, instruction latch, ALU op and retired-instruction counter
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    alu_op_d = alu_op_q;
    cnt_d    = cnt_q;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_ENTRY;
          cnt_d   = '0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
        end
      end
      S_ENTRY: state_d = S_IF;
      S_IF: begin
        ir_d    = ins;
        state_d = S_ID;
      end
      S_ID: begin
        alu_op_d = dec_c.alu_op;
        state_d  = S_EX;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        if (dec_c.illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
`endif
      end
      S_EX:  state_d = (dec_c.is_lw | dec_c.is_s) ? S_MEM : S_WB;
      S_MEM: state_d = S_WB;
      S_WB: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((max_ins != '0) && (cnt_q + CNT_W'(1) == max_ins)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IF;
        end
      end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_IF;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobes computed from the next state so the flops line up with it
  always_comb begin
    int_req_d = (state_d == S_ENTRY);
    pc_en_d   = (state_d == S_ENTRY) || (state_d == S_WB);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    int_req_d = int_req_d || (state_d == S_TRAP);
    pc_en_d   = pc_en_d   || (state_d == S_TRAP);
`endif
    if_en_d   = (state_d == S_IF);
    ex_en_d   = (state_d == S_EX);
    mem_rd_d  = (state_d == S_MEM) && dec_c.is_lw;
    mem_wr_d  = (state_d == S_MEM) && dec_c.is_s;
    wb_en_d   = (state_d == S_WB) && writes_rf_c;
    busy_d    = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d  = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      alu_op_q  <= ALU_ADD;
      cnt_q     <= '0;
      int_req_q <= 1'b0;
      pc_en_q   <= 1'b0;
      if_en_q   <= 1'b0;
      ex_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      cnt_q     <= cnt_d;
      int_req_q <= int_req_d;
      pc_en_q   <= pc_en_d;
      if_en_q   <= if_en_d;
      ex_en_q   <= ex_en_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign ir        = ir_q;
  assign int_req   = int_req_q;
  assign pc_en     = pc_en_q;
  assign if_en     = if_en_q;
  assign ex_en     = ex_en_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign wb_en     = wb_en_q;
  assign alu_op    = alu_op_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign ins_count = cnt_q;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: expected per-instruction behaviour is
// queued at fetch time and checked as the instruction moves through EX/MEM/WB.
`timescale 1ns/1ps
module tb_cpu_seq_ctrl;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] max_ins;
  logic [31:0]   ins;
  logic [31:0]   ir;
  logic          int_req, pc_en, if_en, ex_en, mem_rd, mem_wr, wb_en;
  logic [2:0]    alu_op;
  logic          busy, halted;
  logic [CW-1:0] ins_count;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic          illegal;
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  cpu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .max_ins   (max_ins),
    .ins       (ins),
    .ir        (ir),
    .int_req   (int_req),
    .pc_en     (pc_en),
    .if_en     (if_en),
    .ex_en     (ex_en),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .wb_en     (wb_en),
    .alu_op    (alu_op),
    .busy      (busy),
    .halted    (halted),
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    .illegal   (illegal),
`endif
    .ins_count (ins_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  alu;
    bit          rd;
    bit          wr;
    bit          wb;
    bit          ill;
    int          if_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          pidx;
  int          exp_cnt;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_ADDI = 32'h00508093;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  // Reference behaviour of one instruction word
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    e.word = w; e.alu = 3'b010; e.rd = 0; e.wr = 0; e.wb = 0; e.ill = 0; e.if_cyc = 0;
    case (w[6:0])
      7'h33: begin
        e.wb = 1;
        case (w[14:12])
          3'b000:  e.alu = w[30] ? 3'b110 : 3'b010;
          3'b111:  e.alu = 3'b000;
          3'b110:  e.alu = 3'b001;
          3'b010:  e.alu = 3'b111;
          default: e.alu = 3'b010;
        endcase
      end
      7'h03: begin e.rd = 1; e.wb = 1; end
      7'h13: e.wb = 1;
      7'h23: e.wr = 1;
      7'h6F: e.wb = 1;
      7'h63: e.alu = 3'b110;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; max_ins = '0; ins = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start a run and follow it until n_retire instructions reach WB
  task automatic run(input int n_retire, input logic [CW-1:0] mi, input bit poke);
    int   retired = 0;
    int   budget  = 0;
    exp_t e;
    int   lat;
    pidx = 0; exp_cnt = 0; sb.delete();
    @(negedge clk);
    max_ins = mi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (!(int_req === 1'b1 && pc_en === 1'b1 && busy === 1'b1 && halted === 1'b0))
      begin n_err++; $display("FAIL entry: int_req=%b pc_en=%b busy=%b halted=%b want 1 1 1 0", int_req, pc_en, busy, halted); end
    while (retired < n_retire && budget < 3000) begin
      @(negedge clk);
      budget++;
      start = (poke && (budget % 7 == 3)) ? 1'b1 : 1'b0;
      if (if_en === 1'b1) begin
        ins = (pidx < prog.size()) ? prog[pidx] : I_ADD;
        pidx++;
        e = model(ins);
        e.if_cyc = cyc;
        sb.push_back(e);
      end else if (sb.size() == 0) begin
        if (pc_en || ex_en || mem_rd || mem_wr || wb_en) begin
          n_vec++; n_err++;
          $display("FAIL orphan_strobe: pc_en=%b ex_en=%b mem_rd=%b mem_wr=%b wb_en=%b want none", pc_en, ex_en, mem_rd, mem_wr, wb_en);
        end
      end else if (ex_en === 1'b1) begin
        n_vec++;
        if (alu_op !== sb[0].alu) begin n_err++; $display("FAIL ex_alu_op: got %b want %b ins=%h", alu_op, sb[0].alu, sb[0].word); end
      end else if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
        n_vec++;
        if (mem_rd !== sb[0].rd || mem_wr !== sb[0].wr)
          begin n_err++; $display("FAIL mem_strobe: rd=%b wr=%b want %b %b ins=%h", mem_rd, mem_wr, sb[0].rd, sb[0].wr, sb[0].word); end
      end else if (int_req === 1'b1 && pc_en === 1'b1) begin
        e = sb.pop_front();
        n_vec++;
        if (!(TRAP_EN && e.ill) || ins_count !== CW'(exp_cnt))
          begin n_err++; $display("FAIL trap: ins=%h count=%0d want ill+trap count=%0d", e.word, ins_count, exp_cnt); end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        n_vec++;
        if (illegal !== 1'b1) begin n_err++; $display("FAIL trap_illegal: got %b want 1", illegal); end
`endif
      end else if (pc_en === 1'b1) begin
        e = sb.pop_front();
        lat = cyc - e.if_cyc;
        n_vec++;
        if (ir !== e.word || alu_op !== e.alu || wb_en !== e.wb || int_req !== 1'b0)
          begin n_err++; $display("FAIL wb: ir=%h alu=%b wb_en=%b int_req=%b want %h %b %b 0", ir, alu_op, wb_en, int_req, e.word, e.alu, e.wb); end
        n_vec++;
        if (ins_count !== CW'(exp_cnt) || lat !== ((e.rd || e.wr) ? 4 : 3))
          begin n_err++; $display("FAIL wb_timing: count=%0d lat=%0d want %0d %0d", ins_count, lat, exp_cnt, (e.rd || e.wr) ? 4 : 3); end
        if (TRAP_EN && e.ill) begin n_err++; $display("FAIL trap_missing: ins=%h reached WB want TRAP", e.word); end
        exp_cnt++;
        retired++;
      end
    end
    start = 1'b0;
    if (budget >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: retired=%0d want %0d", retired, n_retire);
    end
    if (mi != '0) begin
      @(negedge clk);
      n_vec++;
      if (halted !== 1'b1 || busy !== 1'b0 || ins_count !== mi || pc_en !== 1'b0 || if_en !== 1'b0)
        begin n_err++; $display("FAIL halt: halted=%b busy=%b count=%0d pc_en=%b if_en=%b want 1 0 %0d 0 0", halted, busy, ins_count, pc_en, if_en, mi); end
    end
  endtask

  task automatic check_idle(input string tag);
    n_vec++;
    if (state_bits() !== 9'b0 || alu_op !== 3'b010 || ins_count !== '0 || ir !== 32'h0)
      begin n_err++; $display("FAIL %s: strobes/busy/halted=%b alu=%b count=%0d ir=%h want 0 010 0 0", tag, state_bits(), alu_op, ins_count, ir); end
  endtask

  function automatic logic [8:0] state_bits();
    return {int_req, pc_en, if_en, ex_en, mem_rd, mem_wr, wb_en, busy, halted};
  endfunction

  task automatic test_reset();
    do_reset();
    check_idle("reset_values");
  endtask

  task automatic test_single_add();
    prog = '{I_ADD};
    run(1, CW'(1), 1'b0);
  endtask

  task automatic test_alu_ops();
    prog = '{I_SUB, I_AND, I_OR, I_SLT, I_BEQ};
    run(5, CW'(5), 1'b0);
  endtask

  task automatic test_mem();
    prog = '{I_LW, I_SW, I_LW, I_ADDI, I_JAL, I_SW};
    run(6, CW'(6), 1'b0);
  endtask

  task automatic test_forever();
    logic [31:0] tbl[10];
    tbl = '{I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_LW, I_SW, I_ADDI, I_JAL, I_BEQ};
    prog.delete();
    for (int i = 0; i < 43; i++) prog.push_back(tbl[$urandom_range(0, 9)]);
    run(43, '0, 1'b1);
    repeat (3) @(negedge clk);
    n_vec++;
    if (halted !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL forever_running: halted=%b busy=%b want 0 1", halted, busy); end
  endtask

  // Reset asserted while an instruction sits in EX
  task automatic test_reset_mid_ex();
    int guard = 0;
    while (ex_en !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    n_vec++;
    if (ex_en !== 1'b1 || ins_count === '0)
      begin n_err++; $display("FAIL reach_ex: ex_en=%b count=%0d want 1 nonzero", ex_en, ins_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_mid_ex");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_illegal();
    prog = '{I_ADD, I_BAD, I_ADD};
    run(2, CW'(2), 1'b0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    n_vec++;
    if (illegal !== 1'b1) begin n_err++; $display("FAIL illegal_sticky: got %b want 1", illegal); end
`endif
    prog = '{I_ADDI};
    run(1, CW'(1), 1'b0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    n_vec++;
    if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_clear: got %b want 0", illegal); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_alu_ops();
    test_mem();
    test_forever();
    test_reset_mid_ex();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
